// File: rtl/clock_period_meter_pkg.sv
// clock_meter_pkg
//   Shared types and default parameters for the clock period meter.
//   - meter_state_t : FSM state encoding (IDLE, ARM, MEASURE)
//   - meter_dbg_t   : debug snapshot exported by the top (FSM state plus
//                     the synchronized input and its edge strobes)
//   - *_DEFAULT     : default parameter values used by the top module
package clock_meter_pkg;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int MAX_CYCLES_DEFAULT  = 2**24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    typedef struct packed {
        meter_state_t state;
        logic         sig_sync;
        logic         sig_rise;
        logic         sig_fall;
    } meter_dbg_t;

endpackage

// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if
//   Request/result bundle between a requester (master) and the meter (slave).
//   Ports carried:
//     start     requester -> meter   request one measurement
//     busy      meter -> requester   ARM or MEASURE in progress
//     done      meter -> requester   one-cycle result strobe
//     timeout   meter -> requester   1 = aborted before a second rising edge arrived
//     period    meter -> requester   fast cycles between two rising edges
//     high_time meter -> requester   fast cycles the input was high
//
// Handshake: start is a level sampled only while the meter is idle
// (busy=0 acts as ready); a start seen while busy is dropped, not queued.
// done is a single-cycle valid with no backpressure; timeout, period and
// high_time are valid in the done cycle and hold until the next done or reset.
interface clock_period_meter_if #(
    parameter int CNT_W = 32
) ();

    logic             start;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    modport master (
        output start,
        input  busy,
        input  done,
        input  timeout,
        input  period,
        input  high_time
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output timeout,
        output period,
        output high_time
    );

endinterface

// File: rtl/clock_period_meter_sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level into the clock domain through a chain of
//   SYNC_STAGES flops (SYNC_STAGES must be >= 2), then registers it once
//   more so both edges can be detected.
//   Ports:
//     clock     in   fast clock
//     reset     in   synchronous, active-high; clears every flop to 0
//     async_in  in   asynchronous input level
//     sync_out  out  synchronized level (last synchronizer stage)
//     rise      out  sync_out & ~previous  (one cycle per rising edge)
//     fall      out  ~sync_out & previous  (one cycle per falling edge)
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising and falling edges pass through the same flops, so the spacing
    // between detected edges equals the spacing seen at the first stage.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures one full cycle of a slow asynchronous signal in fast-clock
//   cycles: the period between two consecutive rising edges and how many of
//   those cycles the signal was high. One measurement per start request,
//   reported through a one-cycle done strobe. If no full cycle is seen within
//   MAX_CYCLES fast cycles the measurement aborts with timeout=1 and zeroed
//   results.
//   Ports:
//     clock   in   fast system clock
//     reset   in   synchronous, active-high; aborts any measurement, no done
//     sig_in  in   asynchronous slow signal to measure
//     bus     slave modport: start in; busy, done, timeout, period,
//             high_time out
//     dbg     out  FSM state and synchronized input / edge strobes
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int MAX_CYCLES  = MAX_CYCLES_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig_in,
    clock_period_meter_if.slave  bus,
    output meter_dbg_t           dbg
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    meter_state_t     state_q;
    meter_state_t     state_d;

    logic             sig_sync;
    logic             sig_rise;
    logic             sig_fall;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] tmo_q;
    logic             tmo_hit;

    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             busy_c;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (sig_in),
        .sync_out (sig_sync),
        .rise     (sig_rise),
        .fall     (sig_fall)
    );

    // Last cycle of the ARM+MEASURE budget; takes priority over a rise.
    assign tmo_hit = (tmo_q == TMO_LAST);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tmo_hit) begin
                    state_d = IDLE;
                end else if (sig_rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (tmo_hit || sig_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs decoded from state
    // ---------------------------------------------------------------
    always_comb begin
        busy_c = 1'b0;
        case (state_q)
            ARM, MEASURE: busy_c = 1'b1;
            default:      busy_c = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Counters and result registers
    //   cnt starts at 1 on the first rise so that the following rise
    //   leaves cnt equal to the edge spacing. hi starts at 1 because the
    //   synchronized input is high in the rise cycle itself.
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                end
                ARM: begin
                    tmo_q <= tmo_q + ONE;
                    if (tmo_hit) begin
                        timeout_q   <= 1'b1;
                        period_q    <= '0;
                        high_time_q <= '0;
                        done_q      <= 1'b1;
                    end else if (sig_rise) begin
                        cnt_q <= ONE;
                        hi_q  <= ONE;
                    end
                end
                MEASURE: begin
                    tmo_q <= tmo_q + ONE;
                    if (tmo_hit) begin
                        timeout_q   <= 1'b1;
                        period_q    <= '0;
                        high_time_q <= '0;
                        done_q      <= 1'b1;
                    end else if (sig_rise) begin
                        timeout_q   <= 1'b0;
                        period_q    <= cnt_q;
                        high_time_q <= hi_q;
                        done_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                        hi_q  <= hi_q + {{(CNT_W-1){1'b0}}, sig_sync};
                    end
                end
                default: begin
                    tmo_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;

    assign dbg.state    = state_q;
    assign dbg.sig_sync = sig_sync;
    assign dbg.sig_rise = sig_rise;
    assign dbg.sig_fall = sig_fall;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
//   Self-checking bench for clock_period_meter. Expected results are queued
//   when a measurement is requested and compared by a monitor on each done.
module tb_clock_period_meter;
    import clock_meter_pkg::*;

    localparam int CNT_W = 32;
    localparam int MAXC  = 64;
    localparam int W     = 1 + 2 * CNT_W;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------
    // DUT
    // ---------------------------------------------------------------
    logic       sig_in;
    meter_dbg_t dbg;
    clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clock_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .sig_in (sig_in),
        .bus    (bus.slave),
        .dbg    (dbg)
    );

    // ---------------------------------------------------------------
    // Input sources: 0 = constant low, 1 = bit 3 of a fast counter,
    // 2 = 50 ns high / 110 ns low pattern at an off-clock phase
    // ---------------------------------------------------------------
    int         mode = 0;
    logic [7:0] fcnt = 8'd0;
    logic       sig_pat = 1'b0;

    always @(posedge clock) fcnt <= fcnt + 8'd1;

    initial begin
        int unsigned phase_off;
        phase_off = $urandom_range(1, 4);
        sig_pat = 1'b0;
        #(phase_off);
        forever begin
            sig_pat = 1'b1;
            #50;
            sig_pat = 1'b0;
            #110;
        end
    end

    assign sig_in = (mode == 0) ? 1'b0 : (mode == 1) ? fcnt[3] : sig_pat;

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack_exp(input logic tmo, input int p, input int h);
        return {tmo, CNT_W'(p), CNT_W'(h)};
    endfunction

    always @(negedge clock) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        if (!reset && bus.done) begin
            done_cnt++;
            checks++;
            got_v = {bus.timeout, bus.period, bus.high_time};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done got=%h required=no_done", got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL sb_result got tmo=%0b period=%0d high=%0d required tmo=%0b period=%0d high=%0d",
                             got_v[W-1], got_v[2*CNT_W-1:CNT_W], got_v[CNT_W-1:0],
                             exp_v[W-1], exp_v[2*CNT_W-1:CNT_W], exp_v[CNT_W-1:0]);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget, input string name);
        int i;
        i = 0;
        while (done_cnt == c0 && i < budget) begin
            tick(1);
            i++;
        end
        checks++;
        if (done_cnt == c0) begin
            failures++;
            $display("FAIL %s no done within %0d cycles", name, budget);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        tick(4);
        check_int("reset_busy", bus.busy, 0);
        check_int("reset_done", bus.done, 0);
        check_int("reset_timeout", bus.timeout, 0);
        check_int("reset_period", bus.period, 0);
        check_int("reset_high_time", bus.high_time, 0);
        check_int("reset_state", dbg.state, IDLE);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_counter_bit3();
        int c0;
        mode = 1;
        tick(20);
        c0 = done_cnt;
        exp_q.push_back(pack_exp(1'b0, 16, 8));
        pulse_start();
        check_int("bit3_busy_after_start", bus.busy, 1);
        wait_done(c0, 100, "bit3_wait");
        tick(40);
        check_int("bit3_single_done", done_cnt, c0 + 1);
    endtask

    task automatic test_phase_offset();
        int c0;
        mode = 2;
        tick(20);
        for (int r = 0; r < 3; r++) begin
            c0 = done_cnt;
            exp_q.push_back(pack_exp(1'b0, 16, 5));
            pulse_start();
            wait_done(c0, 100, "phase_wait");
            tick($urandom_range(1, 7));
        end
    endtask

    task automatic test_timeout();
        int c0;
        int n;
        mode = 0;
        tick(10);
        c0 = done_cnt;
        exp_q.push_back(pack_exp(1'b1, 0, 0));
        pulse_start();
        check_int("tmo_busy", bus.busy, 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_int("tmo_latency", n, MAXC);
        tick(2);
        check_int("tmo_single_done", done_cnt, c0 + 1);
        check_int("tmo_hold_timeout", bus.timeout, 1);
    endtask

    task automatic test_start_while_busy();
        int c0;
        int i;
        mode = 1;
        tick(10);
        c0 = done_cnt;
        exp_q.push_back(pack_exp(1'b0, 16, 8));
        pulse_start();
        i = 0;
        while (done_cnt == c0 && i < 100) begin
            bus.start = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(1);
            i++;
        end
        bus.start = 1'b0;
        checks++;
        if (done_cnt == c0) begin
            failures++;
            $display("FAIL busy_start_wait no done within 100 cycles");
        end
        tick(40);
        check_int("busy_start_single_done", done_cnt, c0 + 1);
        check_int("busy_start_idle", bus.busy, 0);
    endtask

    task automatic test_reset_mid();
        int c0;
        int i;
        mode = 1;
        tick(10);
        pulse_start();
        i = 0;
        while (dbg.state !== MEASURE && i < 50) begin
            tick(1);
            i++;
        end
        check_int("rmid_reached_measure", dbg.state, MEASURE);
        tick(5);
        c0 = done_cnt;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_int("rmid_busy", bus.busy, 0);
        check_int("rmid_period", bus.period, 0);
        check_int("rmid_high_time", bus.high_time, 0);
        check_int("rmid_done", bus.done, 0);
        tick(40);
        check_int("rmid_no_done", done_cnt, c0);
        c0 = done_cnt;
        exp_q.push_back(pack_exp(1'b0, 16, 8));
        pulse_start();
        wait_done(c0, 100, "rmid_after_wait");
    endtask

    task automatic test_back_to_back();
        int c0;
        int cyc;
        int last;
        int seen;
        mode = 1;
        tick(10);
        c0 = done_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back(pack_exp(1'b0, 16, 8));
        bus.start = 1'b1;
        cyc = 0;
        last = -1;
        seen = 0;
        while (seen < 4 && cyc < 400) begin
            tick(1);
            cyc++;
            if (bus.done === 1'b1) begin
                seen++;
                if (seen == 4) bus.start = 1'b0;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last < 16 || cyc - last > 32) begin
                        failures++;
                        $display("FAIL b2b_interval got=%0d required=16..32", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        bus.start = 1'b0;
        tick(40);
        check_int("b2b_done_count", done_cnt, c0 + 4);
        check_int("b2b_idle", bus.busy, 0);
    endtask

    // ---------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------
    initial begin
        bus.start = 1'b0;
        test_reset();
        test_counter_bit3();
        test_phase_offset();
        test_timeout();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        check_int("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
